// File: rtl/bram_pkg.sv
// Shared constants and types for the BRAM port client.
package bram_pkg;

    localparam int unsigned BRAM_ADDR_W = 10;
    localparam int unsigned BRAM_DATA_W = 36;
    localparam int unsigned BRAM_DEPTH  = 1024;

    // Response FIFO entry layout when write acks are enabled: {is_write, data}.
    typedef struct packed {
        logic                   is_write;
        logic [BRAM_DATA_W-1:0] data;
    } resp_entry_t;

    // Pointer width for a FIFO of the given depth (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH and occupancy is an
// explicit counter. Head word reads as zero while empty.
module bram_resp_fifo
    import bram_pkg::*;
#(
    parameter  int unsigned DEPTH = 3,
    parameter  int unsigned WIDTH = BRAM_DATA_W,
    localparam int unsigned PTR_W = ptr_w(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             pop_ok;
    logic             push_ok;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        empty    = (count_q == '0);
        pop_ok   = pop && !empty;
        push_ok  = push && ((count_q < CNT_W'(DEPTH)) || pop_ok);

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/bram_port_client.sv
// Valid/ready request front end for one BRAM port, with an in-order,
// credit-protected read response FIFO.
// Optional feature: define BRAM_CLIENT_WRITE_ACK_EN to return write acks.
module bram_port_client
    import bram_pkg::*;
#(
    parameter int unsigned ADDR_W     = BRAM_ADDR_W,
    parameter int unsigned DATA_W     = BRAM_DATA_W,
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic              io_req_write,
    input  logic [ADDR_W-1:0] io_req_addr,
    input  logic [DATA_W-1:0] io_req_data,
    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [DATA_W-1:0] io_resp_data,
    output logic              io_resp_isWrite,
    output logic              io_bram_en,
    output logic              io_bram_writeEn,
    output logic [ADDR_W-1:0] io_bram_addr,
    output logic [DATA_W-1:0] io_bram_dataIn,
    input  logic [DATA_W-1:0] io_bram_dataOut
);

    localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);
`ifdef BRAM_CLIENT_WRITE_ACK_EN
    localparam int unsigned ENTRY_W = DATA_W + 1;
`else
    localparam int unsigned ENTRY_W = DATA_W;
`endif

    logic              active_q, active_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
`ifdef BRAM_CLIENT_WRITE_ACK_EN
    logic              pend_write_q, pend_write_d;
`endif

    logic               fire;
    logic               resp_fire;
    logic               pop;
    logic [ENTRY_W-1:0] push_word;
    logic [ENTRY_W-1:0] head_word;
    logic [CRED_W-1:0]  fifo_count;

    // Request acceptance, port drive, credit accounting and FIFO push word.
    always_comb begin
        active_d     = 1'b1;
        io_req_ready = active_q && (credits_q < CRED_W'(FIFO_DEPTH));
        fire         = io_req_valid && io_req_ready;
`ifdef BRAM_CLIENT_WRITE_ACK_EN
        resp_fire    = fire;
        pend_write_d = fire && io_req_write;
        push_word    = {pend_write_q, pend_write_q ? DATA_W'(0) : io_bram_dataOut};
`else
        resp_fire    = fire && !io_req_write;
        push_word    = io_bram_dataOut;
`endif
        rd_pend_d       = resp_fire;
        io_bram_en      = fire;
        io_bram_writeEn = fire && io_req_write;
        io_bram_addr    = fire ? io_req_addr : addr_q;
        io_bram_dataIn  = fire ? io_req_data : data_q;
        addr_d          = io_bram_addr;
        data_d          = io_bram_dataIn;

        io_resp_valid = (fifo_count != '0);
        pop           = io_resp_valid && io_resp_ready;

        case ({resp_fire, pop})
            2'b10:   credits_d = credits_q + CRED_W'(1);
            2'b01:   credits_d = credits_q - CRED_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    // State registers; reset drops every in-flight request immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_q  <= 1'b0;
            credits_q <= '0;
            rd_pend_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
`ifdef BRAM_CLIENT_WRITE_ACK_EN
            pend_write_q <= 1'b0;
`endif
        end else begin
            active_q  <= active_d;
            credits_q <= credits_d;
            rd_pend_q <= rd_pend_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
`ifdef BRAM_CLIENT_WRITE_ACK_EN
            pend_write_q <= pend_write_d;
`endif
        end
    end

    bram_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_resp_fifo (
        .clk       (clock),
        .rst       (reset),
        .push      (rd_pend_q),
        .push_data (push_word),
        .pop       (pop),
        .head_data (head_word),
        .count     (fifo_count)
    );

`ifdef BRAM_CLIENT_WRITE_ACK_EN
    assign io_resp_isWrite = head_word[ENTRY_W-1];
    assign io_resp_data    = head_word[DATA_W-1:0];
`else
    assign io_resp_isWrite = 1'b0;
    assign io_resp_data    = head_word;
`endif

endmodule

// File: tb/tb_bram_port_client.sv
// Bench for bram_port_client: directed steps plus a random phase, checked
// against a queue-based model of outstanding responses and a shadow memory.
module tb_bram_port_client;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 36;
    localparam int unsigned DEPTH = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          resp_valid, resp_ready, resp_is_write;
    logic [DW-1:0] resp_data;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;

    always #5 clock = ~clock;

    bram_port_client #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_req_valid    (req_valid),
        .io_req_ready    (req_ready),
        .io_req_write    (req_write),
        .io_req_addr     (req_addr),
        .io_req_data     (req_data),
        .io_resp_valid   (resp_valid),
        .io_resp_ready   (resp_ready),
        .io_resp_data    (resp_data),
        .io_resp_isWrite (resp_is_write),
        .io_bram_en      (bram_en),
        .io_bram_writeEn (bram_we),
        .io_bram_addr    (bram_addr),
        .io_bram_dataIn  (bram_din),
        .io_bram_dataOut (bram_dout)
    );

    // Simple BRAM port: write on enable+we, registered read otherwise.
    logic [DW-1:0] bram_mem [1024];
    always @(posedge clock) begin
        if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_din;
            else         bram_dout <= bram_mem[bram_addr];
        end
    end

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        int            avail;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] shadow [1024];
    bit            active_m;
    int            cycle;
    int            checks;
    int            errors;
    int            fires;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 64'h0_0ABC_D123 + 64'd7);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic w, input int a, input logic [DW-1:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = AW'(a);
        req_data  = d;
    endtask

    // One clock cycle: check outputs against the model, advance the model.
    task automatic cyc();
        logic exp_ready;
        logic exp_valid;
        logic fire;
        exp_t e;
        #1;
        exp_ready = active_m && (expq.size() < int'(DEPTH));
        exp_valid = (expq.size() != 0) && (expq[0].avail <= cycle);
        fire      = req_valid && exp_ready;
        check("req_ready", req_ready, exp_ready);
        check("resp_valid", resp_valid, exp_valid);
        check("bram_en", bram_en, fire);
        check("bram_we", bram_we, fire && req_write);
        if (fire) begin
            check("bram_addr", bram_addr, req_addr);
            if (req_write) check("bram_din", bram_din, req_data);
        end
        if (exp_valid && resp_ready) begin
            e = expq.pop_front();
            check("resp_data", resp_data, e.d);
            check("resp_isWrite", resp_is_write, e.w);
        end
        if (fire) begin
            fires++;
            if (req_write) begin
                shadow[req_addr] = req_data;
`ifdef BRAM_CLIENT_WRITE_ACK_EN
                expq.push_back('{w: 1'b1, d: '0, avail: cycle + 2});
`endif
            end else begin
                expq.push_back('{w: 1'b0, d: shadow[req_addr], avail: cycle + 2});
            end
        end
        @(posedge clock);
        cycle++;
        if (!reset) active_m = 1'b1;
        @(negedge clock);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        set_req(0, 0, 0, '0);
        resp_ready = 1'b1;
        while (expq.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        check(tag, expq.size(), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fires  = 0;
        cycle  = 0;
        active_m = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            bram_mem[i] = init_val(i);
            shadow[i]   = init_val(i);
        end
        bram_dout  = '0;
        reset      = 1'b1;
        resp_ready = 1'b0;
        set_req(0, 0, 0, '0);

        // Reset values.
        @(negedge clock);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_isWrite", resp_is_write, 0);
        @(negedge clock);
        reset = 1'b0;
        cyc();

        // Write then read back the same address.
        resp_ready = 1'b1;
        set_req(1, 1, 5, 36'h123456789);
        cyc();
        set_req(1, 0, 5, '0);
        cyc();
        set_req(0, 0, 0, '0);
`ifdef BRAM_CLIENT_WRITE_ACK_EN
        cyc();
`endif
        cyc();
        #1;
        check("t1_valid", resp_valid, 1);
        check("t1_data", resp_data, 36'h123456789);
        cyc();
        drain("t1_drain");

        // 16 back-to-back reads with the consumer always ready.
        fires = 0;
        for (int i = 0; i < 16; i++) begin
            set_req(1, 0, i, '0);
            #1;
            check("t2_ready", req_ready, 1);
            cyc();
        end
        check("t2_fires", fires, 16);
        drain("t2_drain");

        // Backpressure: only FIFO_DEPTH reads may be outstanding.
        resp_ready = 1'b0;
        fires = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(1, 0, 20 + i, '0);
            cyc();
        end
        check("t3_fires", fires, DEPTH);
        #1;
        check("t3_ready_low", req_ready, 0);
        drain("t3_drain");

        // Asynchronous reset with two reads queued.
        resp_ready = 1'b0;
        set_req(1, 0, 40, '0);
        cyc();
        set_req(1, 0, 41, '0);
        cyc();
        set_req(0, 0, 0, '0);
        cyc();
        cyc();
        check("t4_queued", expq.size(), 2);
        #2;
        reset = 1'b1;
        #1;
        check("t4_resp_valid", resp_valid, 0);
        check("t4_req_ready", req_ready, 0);
        check("t4_bram_en", bram_en, 0);
        expq.delete();
        active_m = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        // Interleaved write / read / write.
        set_req(1, 1, 10, 36'hA_5A5A_5A5A);
        cyc();
        set_req(1, 0, 10, '0);
        cyc();
        set_req(1, 1, 11, 36'h0_1234_5678);
        cyc();
        drain("t5_drain");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_req($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), DW'({$urandom(), $urandom()}));
            resp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
